// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_pkg
// Purpose  : Shared FSM state type, default geometry and trigger helper for
//            the ADC capture block.
// Revision : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int c_dw_default       = 14;
    localparam int c_depth_default    = 1024;
    localparam int c_pre_trig_default = 256;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Edge detection on the "at or above level" view of two consecutive samples.
    function automatic logic trig_hit(input logic rising,
                                      input logic prev_ge,
                                      input logic cur_ge);
        return rising ? (!prev_ge && cur_ge) : (prev_ge && !cur_ge);
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : capture_ram
// Purpose  : Simple dual-port sample RAM, one write port and one registered
//            read port on the same clock.
// Revision : 1.0 - initial release
// ============================================================================
module capture_ram #(
    parameter int DW = 14,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [1 << AW];
    logic [DW-1:0] r_rd_data;

    // The array itself is never reset so the previous capture survives a reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Purpose  : Pre/post-trigger ADC sample capture into a circular buffer.
//            Optional ADC_CAPTURE_DECIM_EN adds a decim port (keep every
//            (decim+1)-th sample).
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DW       = c_dw_default,
    parameter int DEPTH    = c_depth_default,
    parameter int PRE_TRIG = c_pre_trig_default
) (
    input  logic                     CLK_ADC,
    input  logic                     RST,
    input  logic [DW-1:0]            adc_in,
    input  logic                     arm,
    input  logic                     force_trig,
    input  logic                     trig_rising,
    input  logic [DW-1:0]            trig_level,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [7:0]               decim,
`endif
    output logic                     busy,
    output logic                     done,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);

    localparam int              c_aw        = $clog2(DEPTH);
    localparam int              c_post_len  = DEPTH - PRE_TRIG;
    localparam logic [c_aw-1:0] c_one       = c_aw'(1);
    localparam logic [c_aw-1:0] c_pre_off   = c_aw'(PRE_TRIG);
    localparam logic [c_aw-1:0] c_pre_last  = c_aw'(PRE_TRIG - 1);
    localparam logic [c_aw-1:0] c_post_last = c_aw'(c_post_len - 1);

    state_t          r_state;
    logic [DW-1:0]   r_sample;
    logic [DW-1:0]   r_prev;
    logic [c_aw-1:0] r_cnt;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_trig_ptr;
    logic            r_busy;
    logic            r_done;

    logic            w_samp_en;
    logic            w_arm_ok;
    logic            w_capturing;
    logic            w_wr_en;
    logic            w_trig;
    logic [c_aw-1:0] w_rd_addr;

    assign w_arm_ok    = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_wr_en     = w_capturing && w_samp_en;
    assign w_trig      = trig_hit(trig_rising, (r_prev >= trig_level), (r_sample >= trig_level))
                         || force_trig;

`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0] r_dec_cnt;

    // Restarting on an accepted arm makes the first sample after arm always count.
    always_ff @(posedge CLK_ADC or posedge RST) begin
        if (RST) begin
            r_dec_cnt <= 8'd0;
        end else if (w_arm_ok || (r_dec_cnt == decim)) begin
            r_dec_cnt <= 8'd0;
        end else begin
            r_dec_cnt <= r_dec_cnt + 8'd1;
        end
    end

    assign w_samp_en = (r_dec_cnt == 8'd0);
`else
    assign w_samp_en = 1'b1;
`endif

    always_ff @(posedge CLK_ADC or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_sample   <= '0;
            r_prev     <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_trig_ptr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sample <= adc_in;
            if (w_samp_en) begin
                r_prev <= r_sample;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        r_state <= S_PRE;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_PRE: begin
                    if (w_samp_en) begin
                        if (r_cnt == c_pre_last) begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end
                S_WAIT: begin
                    // The trigger sample itself is the first post-trigger write.
                    if (w_samp_en && w_trig) begin
                        r_trig_ptr <= r_wr_ptr;
                        if (c_post_len == 1) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_POST;
                            r_cnt   <= c_one;
                        end
                    end
                end
                S_POST: begin
                    if (w_samp_en) begin
                        if (r_cnt == c_post_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Logical index 0 is the oldest pre-trigger sample; wraps modulo DEPTH.
    assign w_rd_addr = r_trig_ptr - c_pre_off + rd_addr;

    capture_ram #(
        .DW (DW),
        .AW (c_aw)
    ) u_ram (
        .clk       (CLK_ADC),
        .rst       (RST),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (r_sample),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (rd_data)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
